// File: rtl/bram_rd_fifo2.sv
// Two-entry in-order buffer of {last, data} words sitting behind the BRAM read port.
// Callers must not push when full or pop when empty.
module bram_rd_fifo2 #(
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [word_size-1:0] push_data,
    input  logic                 push_last,
    input  logic                 pop,
    output logic [word_size-1:0] head_data,
    output logic                 head_last,
    output logic [1:0]           count
);

    logic [word_size:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // The last flag is masked when empty so a stale entry never shows a last.
    assign head_data = mem_q[rd_ptr_q][word_size-1:0];
    assign head_last = mem_q[rd_ptr_q][word_size] & (count_q != 2'd0);
    assign count     = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams len consecutive BRAM words from base_addr as a valid/ready stream,
// hiding the 1-cycle read latency with a credit-limited 2-entry output buffer.
module bram_stream_reader #(
    parameter int word_size = 32,
    parameter int addr_size = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [addr_size-1:0] base_addr,
    input  logic [addr_size:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_en,
    output logic [addr_size-1:0] bram_r_addr,
    input  logic [word_size-1:0] bram_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [word_size-1:0] out_data,
    output logic                 out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [addr_size-1:0] ADDR_ONE = 1;
    localparam logic [addr_size:0]   CNT_ONE  = 1;
    localparam logic [addr_size:0]   CNT_ZERO = 0;

    logic [1:0]           state_q, state_d;
    logic [addr_size-1:0] rd_addr_q, rd_addr_d;
    logic [addr_size:0]   rd_left_q, rd_left_d;
    logic [addr_size:0]   push_left_q, push_left_d;
    logic                 pending_q, pending_d;
    logic                 done_q, done_d;

    logic [1:0]           fifo_count;
    logic                 head_last;
    logic                 pop;
    logic                 push_last;
    logic [2:0]           occupancy;
    logic                 issue;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push_last = (push_left_q == CNT_ONE);

    // Words already read but not yet consumed may never exceed the buffer depth.
    assign occupancy = {1'b0, fifo_count} + {2'b00, pending_q} - {2'b00, pop};
    assign issue     = (state_q == S_RUN) && (occupancy < 3'd2);

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rd_left_d   = rd_left_q;
        push_left_d = push_left_q;
        pending_d   = issue;
        done_d      = 1'b0;

        if (issue) begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
            rd_left_d = rd_left_q - CNT_ONE;
        end
        if (pending_q) begin
            push_left_d = push_left_q - CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != CNT_ZERO) begin
                        state_d     = S_RUN;
                        rd_addr_d   = base_addr;
                        rd_left_d   = len;
                        push_left_d = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue && (rd_left_q == CNT_ONE)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            rd_left_q   <= '0;
            push_left_q <= '0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_left_q   <= rd_left_d;
            push_left_q <= push_left_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
        end
    end

    bram_rd_fifo2 #(
        .word_size(word_size)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending_q),
        .push_data (bram_dout),
        .push_last (push_last),
        .pop       (pop),
        .head_data (out_data),
        .head_last (head_last),
        .count     (fifo_count)
    );

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign bram_en     = issue;
    assign bram_r_addr = rd_addr_q;
    assign out_last    = head_last;

endmodule
